// File: rtl/shift_issue_stage.sv
// Two-stage shift/rotate issue stage: stage 1 holds the operation and drives an
// external combinational funnel shifter, stage 2 registers the selected result and flags.
module shift_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_data,
    input  logic [5:0]       in_amt,
    output logic [31:0]      fs_a,
    output logic [31:0]      fs_b,
    output logic             fs_side,
    output logic [5:0]       fs_shift,
    input  logic [63:0]      fs_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic        s1_valid;
    logic [2:0]  s1_op;
    logic [31:0] s1_x;
    logic [4:0]  s1_n;
    logic        s2_valid;
    logic        s2_adv;
    logic        in_fire;

    logic        is_legal;
    logic        is_left;
    logic [31:0] result;
    logic        carry;
    logic [4:0]  left_idx;
    logic [4:0]  right_idx;

    // Amount bit 5 is deliberately dropped: shifts are modulo 32.
    logic        unused_amt_msb;
    assign unused_amt_msb = in_amt[5];

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= 3'b000;
            s1_x     <= '0;
            s1_n     <= '0;
            op_count <= '0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_adv);
            if (in_fire) begin
                s1_op    <= in_op;
                s1_x     <= in_data;
                s1_n     <= in_amt[4:0];
                op_count <= op_count + 1'b1;
            end
        end
    end

    always_comb begin
        is_legal = 1'b1;
        is_left  = 1'b0;
        fs_a     = '0;
        fs_b     = '0;
        unique case (s1_op)
            OP_SLL: begin fs_a = s1_x;          fs_b = '0;   is_left = 1'b1; end
            OP_SRL: begin fs_a = '0;            fs_b = s1_x; end
            OP_SRA: begin fs_a = {32{s1_x[31]}}; fs_b = s1_x; end
            OP_ROL: begin fs_a = s1_x;          fs_b = s1_x; is_left = 1'b1; end
            OP_ROR: begin fs_a = s1_x;          fs_b = s1_x; end
            default: is_legal = 1'b0;
        endcase
        // An empty stage 1 parks the funnel at all-zero inputs.
        if (!s1_valid) begin
            fs_a = '0;
            fs_b = '0;
        end
    end

    assign fs_side  = s1_valid && is_left;
    assign fs_shift = s1_valid ? {1'b0, s1_n} : 6'd0;

    assign left_idx  = 5'(6'd32 - {1'b0, s1_n});
    assign right_idx = s1_n - 5'd1;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        if (is_legal) begin
            result = is_left ? fs_out[63:32] : fs_out[31:0];
            if (s1_n != 5'd0)
                carry = is_left ? s1_x[left_idx] : s1_x[right_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            out_result  <= '0;
            out_carry   <= 1'b0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= result;
                out_carry   <= carry;
                out_zero    <= (result == 32'd0);
                out_illegal <= !is_legal;
            end
        end
    end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with a behavioural 64-bit funnel shifter model.
module tb_shift_issue_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_data;
    logic [5:0]       in_amt;
    logic [31:0]      fs_a;
    logic [31:0]      fs_b;
    logic             fs_side;
    logic [5:0]       fs_shift;
    logic [63:0]      fs_out;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_illegal;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    shift_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_amt(in_amt),
        .fs_a(fs_a), .fs_b(fs_b), .fs_side(fs_side), .fs_shift(fs_shift),
        .fs_out(fs_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .out_illegal(out_illegal),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Funnel shifter: concatenate {a,b} and shift the 64-bit word.
    always_comb begin
        if (fs_side) fs_out = {fs_a, fs_b} << fs_shift;
        else         fs_out = {fs_a, fs_b} >> fs_shift;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [5:0]  amt;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] bp_data[3];
    logic [31:0] bp_exp[2];
    int p;
    int acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; in_amt = '0; out_ready = 1'b1;

        vecs[0]  = '{3'b000, 32'h0000_00F1, 6'd4,  32'h0000_0F10, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b010, 32'h8000_0001, 6'd1,  32'hC000_0000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 32'h8000_0001, 6'd1,  32'h4000_0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b011, 32'h8000_0001, 6'd4,  32'h0000_0018, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b100, 32'h0000_0001, 6'd1,  32'h8000_0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 32'h1234_5678, 6'd32, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b000, 32'h8000_0001, 6'd33, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'b001, 32'h8000_0000, 6'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b000, 32'h0000_0003, 6'd31, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b001, 32'h0000_0001, 6'd1,  32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{3'b110, 32'hFFFF_FFFF, 6'd5,  32'h0000_0000, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{3'b010, 32'h7FFF_FFFF, 6'd4,  32'h07FF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{3'b100, 32'h0000_000F, 6'd4,  32'hF000_0000, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{3'b111, 32'h1234_5678, 6'd0,  32'h0000_0000, 1'b0, 1'b1, 1'b1};

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_fs_a", fs_a, 32'd0);
        chk("rst_fs_side", 32'(fs_side), 32'd0);
        chk("rst_fs_shift", 32'(fs_shift), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single ops: accept at edge N, result visible after edge N+1.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = vecs[i].op; in_data = vecs[i].x; in_amt = vecs[i].amt;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_latency", i), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d_fs_shift", i), 32'(fs_shift), {27'd0, vecs[i].amt[4:0]});
            chk($sformatf("v%0d_op_count", i), 32'(op_count), 32'(i + 1));
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
            chk($sformatf("v%0d_carry", i), 32'(out_carry), 32'(vecs[i].c));
            chk($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].z));
            chk($sformatf("v%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
        end

        // Back-to-back: 8 SLL-by-1 ops, results on consecutive cycles.
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("b2b%0d_valid", c), 32'(out_valid), 32'd1);
                chk($sformatf("b2b%0d_result", c), out_result, 32'(c - 1) << 1);
            end
            if (c < 8) begin
                in_valid = 1'b1; in_op = 3'b000; in_data = 32'(c + 1); in_amt = 6'd1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_drained", 32'(out_valid), 32'd0);
        chk("b2b_op_count", 32'(op_count), 32'd8);
        // Eight more accepts wrap the 4-bit counter back to zero.
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_op = 3'b001; in_data = 32'h100; in_amt = 6'd4;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("wrap_op_count", 32'(op_count), 32'd0);

        // Backpressure: out_ready low for 5 cycles with upstream always valid.
        do_reset();
        bp_data[0] = 32'h11; bp_data[1] = 32'h22; bp_data[2] = 32'h33;
        bp_exp[0] = 32'h110; bp_exp[1] = 32'h220;
        out_ready = 1'b0; p = 0; acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) chk($sformatf("bp%0d_stable", c), out_result, bp_exp[0]);
            in_valid = 1'b1; in_op = 3'b000; in_data = bp_data[p]; in_amt = 6'd4;
            if (in_ready) begin
                acc++;
                if (p < 2) p++;
            end
        end
        @(negedge clk);
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_held_result", out_result, bp_exp[0]);
        chk("bp_op_count", 32'(op_count), 32'd2);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain1_valid", 32'(out_valid), 32'd1);
        chk("bp_drain1_result", out_result, bp_exp[1]);
        @(negedge clk);
        chk("bp_drain_done", 32'(out_valid), 32'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = 3'b011; in_data = 32'hA5A5_0000 + 32'(c); in_amt = 6'd3;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_op_count", 32'(op_count), 32'd0);
        chk("mid_rst_fs_a", fs_a, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_valid", c), 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
